// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement queue with CDB capture and branch-mispredict flush.
// Optional feature: define ROB_COMMIT_COUNTER_EN to add a 32-bit commit_count output
// counting every normal pop.
module reorder_buffer #(
  parameter int unsigned ROB_DEPTH     = 16,
  parameter int unsigned ROB_ID_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     ID_alloc_valid,
  input  logic [REG_IDX_WIDTH-1:0] ID_rd,
  input  logic                     ID_is_branch,
  output logic [ROB_ID_WIDTH-1:0]  alloc_ROB_id,
  output logic                     ROB_full,
  input  logic                     CDB_valid,
  input  logic [ROB_ID_WIDTH-1:0]  CDB_ROB_id,
  input  logic [DATA_WIDTH-1:0]    CDB_value,
  input  logic                     CDB_mispredict,
  input  logic [DATA_WIDTH-1:0]    CDB_target,
  input  logic [ROB_ID_WIDTH-1:0]  query_ROB_id,
  output logic                     query_ready,
  output logic [DATA_WIDTH-1:0]    query_value,
  output logic                     ROB_input_valid,
  output logic [REG_IDX_WIDTH-1:0] ROB_rd,
  output logic [DATA_WIDTH-1:0]    ROB_value,
  output logic [ROB_ID_WIDTH-1:0]  ROB_rd_ROB_id,
  output logic                     ROB_roll_back_flag,
`ifdef ROB_COMMIT_COUNTER_EN
  output logic [31:0]              commit_count,
`endif
  output logic [DATA_WIDTH-1:0]    ROB_roll_back_pc
);

  typedef logic [ROB_ID_WIDTH-1:0] id_t;
  typedef logic [ROB_ID_WIDTH:0]   cnt_t;
  localparam id_t  IdOne   = id_t'(1);
  localparam cnt_t CntFull = cnt_t'(ROB_DEPTH);

  id_t  head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [ROB_DEPTH-1:0]     busy_q, busy_d, ready_q, ready_d, br_q, br_d, mis_q, mis_d;
  logic [REG_IDX_WIDTH-1:0] rd_q    [ROB_DEPTH];
  logic [REG_IDX_WIDTH-1:0] rd_d    [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]    value_q [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]    value_d [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]    tgt_q   [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]    tgt_d   [ROB_DEPTH];

  logic                     out_valid_q, out_valid_d, rb_q, rb_d;
  logic [REG_IDX_WIDTH-1:0] out_rd_q, out_rd_d;
  logic [DATA_WIDTH-1:0]    out_value_q, out_value_d, rb_pc_q, rb_pc_d;
  id_t                      out_id_q, out_id_d;

  logic head_done, do_alloc, do_pop, do_flush, cdb_hit;

  // Status and operand lookup straight from current state.
  always_comb begin
    ROB_full     = (count_q == CntFull);
    alloc_ROB_id = tail_q;
    query_ready  = busy_q[query_ROB_id] && ready_q[query_ROB_id];
    query_value  = query_ready ? value_q[query_ROB_id] : '0;
    head_done    = busy_q[head_q] && ready_q[head_q];
    do_alloc     = rdy && ID_alloc_valid && !ROB_full;
    do_pop       = rdy && head_done && !mis_q[head_q];
    do_flush     = rdy && head_done && mis_q[head_q];
    cdb_hit      = rdy && CDB_valid && busy_q[CDB_ROB_id];
  end

  // Next-state: allocate at tail, capture CDB, retire head or flush on mispredict.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    br_d        = br_q;
    mis_d       = mis_q;
    rd_d        = rd_q;
    value_d     = value_q;
    tgt_d       = tgt_q;
    out_valid_d = 1'b0;
    rb_d        = 1'b0;
    out_rd_d    = out_rd_q;
    out_value_d = out_value_q;
    out_id_d    = out_id_q;
    rb_pc_d     = rb_pc_q;

    if (do_alloc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      mis_d[tail_q]   = 1'b0;
      br_d[tail_q]    = ID_is_branch;
      rd_d[tail_q]    = ID_rd;
      tail_d          = tail_q + IdOne;
    end

    if (cdb_hit) begin
      ready_d[CDB_ROB_id] = 1'b1;
      value_d[CDB_ROB_id] = CDB_value;
      if (br_q[CDB_ROB_id]) begin
        mis_d[CDB_ROB_id] = CDB_mispredict;
        tgt_d[CDB_ROB_id] = CDB_target;
      end
    end

    if (do_pop) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + IdOne;
      // x0 and branches retire silently.
      out_valid_d    = (rd_q[head_q] != '0) && !br_q[head_q];
      out_rd_d       = rd_q[head_q];
      out_value_d    = value_q[head_q];
      out_id_d       = head_q;
    end

    count_d = count_q + cnt_t'(do_alloc) - cnt_t'(do_pop);

    // Flush overrides any allocation or writeback made this cycle.
    if (do_flush) begin
      busy_d      = '0;
      ready_d     = '0;
      mis_d       = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      rb_d        = 1'b1;
      rb_pc_d     = tgt_q[head_q];
      out_valid_d = 1'b0;
    end
  end

  // State and registered commit/flush outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      ready_q     <= '0;
      br_q        <= '0;
      mis_q       <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
        tgt_q[i]   <= '0;
      end
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_value_q <= '0;
      out_id_q    <= '0;
      rb_q        <= 1'b0;
      rb_pc_q     <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      br_q        <= br_d;
      mis_q       <= mis_d;
      rd_q        <= rd_d;
      value_q     <= value_d;
      tgt_q       <= tgt_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_value_q <= out_value_d;
      out_id_q    <= out_id_d;
      rb_q        <= rb_d;
      rb_pc_q     <= rb_pc_d;
    end
  end

  assign ROB_input_valid    = out_valid_q;
  assign ROB_rd             = out_rd_q;
  assign ROB_value          = out_value_q;
  assign ROB_rd_ROB_id      = out_id_q;
  assign ROB_roll_back_flag = rb_q;
  assign ROB_roll_back_pc   = rb_pc_q;

`ifdef ROB_COMMIT_COUNTER_EN
  logic [31:0] commit_count_q;

  // Counts every normal pop, including silent x0/branch retirements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_count_q <= '0;
    end else if (do_pop) begin
      commit_count_q <= commit_count_q + 32'd1;
    end
  end

  assign commit_count = commit_count_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus hand-written corner sequences.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        ID_alloc_valid = 1'b0;
  logic [4:0]  ID_rd = '0;
  logic        ID_is_branch = 1'b0;
  logic [3:0]  alloc_ROB_id;
  logic        ROB_full;
  logic        CDB_valid = 1'b0;
  logic [3:0]  CDB_ROB_id = '0;
  logic [31:0] CDB_value = '0;
  logic        CDB_mispredict = 1'b0;
  logic [31:0] CDB_target = '0;
  logic [3:0]  query_ROB_id = '0;
  logic        query_ready;
  logic [31:0] query_value;
  logic        ROB_input_valid;
  logic [4:0]  ROB_rd;
  logic [31:0] ROB_value;
  logic [3:0]  ROB_rd_ROB_id;
  logic        ROB_roll_back_flag;
  logic [31:0] ROB_roll_back_pc;
`ifdef ROB_COMMIT_COUNTER_EN
  logic [31:0] commit_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .ID_alloc_valid     (ID_alloc_valid),
    .ID_rd              (ID_rd),
    .ID_is_branch       (ID_is_branch),
    .alloc_ROB_id       (alloc_ROB_id),
    .ROB_full           (ROB_full),
    .CDB_valid          (CDB_valid),
    .CDB_ROB_id         (CDB_ROB_id),
    .CDB_value          (CDB_value),
    .CDB_mispredict     (CDB_mispredict),
    .CDB_target         (CDB_target),
    .query_ROB_id       (query_ROB_id),
    .query_ready        (query_ready),
    .query_value        (query_value),
    .ROB_input_valid    (ROB_input_valid),
    .ROB_rd             (ROB_rd),
    .ROB_value          (ROB_value),
    .ROB_rd_ROB_id      (ROB_rd_ROB_id),
    .ROB_roll_back_flag (ROB_roll_back_flag),
`ifdef ROB_COMMIT_COUNTER_EN
    .commit_count       (commit_count),
`endif
    .ROB_roll_back_pc   (ROB_roll_back_pc)
  );

  typedef struct {
    logic        rst_before;
    logic        alloc;
    logic [4:0]  rd;
    logic        br;
    logic        cv;
    logic [3:0]  cid;
    logic [31:0] cval;
    logic        mis;
    logic [31:0] tgt;
    logic [3:0]  e_aid;
    logic        e_full;
    logic        e_v;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic [3:0]  e_id;
    logic        e_rb;
    logic [31:0] e_pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_alloc_valid = 1'b0;
    ID_rd          = '0;
    ID_is_branch   = 1'b0;
    CDB_valid      = 1'b0;
    CDB_ROB_id     = '0;
    CDB_value      = '0;
    CDB_mispredict = 1'b0;
    CDB_target     = '0;
    query_ROB_id   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(ROB_input_valid), 0);
    chk("rst_rb", 32'(ROB_roll_back_flag), 0);
    chk("rst_aid", 32'(alloc_ROB_id), 0);
    chk("rst_full", 32'(ROB_full), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.rst_before) do_reset();
    ID_alloc_valid = v.alloc;
    ID_rd          = v.rd;
    ID_is_branch   = v.br;
    CDB_valid      = v.cv;
    CDB_ROB_id     = v.cid;
    CDB_value      = v.cval;
    CDB_mispredict = v.mis;
    CDB_target     = v.tgt;
    #1;
    chk($sformatf("vec%0d_aid", idx), 32'(alloc_ROB_id), 32'(v.e_aid));
    chk($sformatf("vec%0d_full", idx), 32'(ROB_full), 32'(v.e_full));
    step();
    chk($sformatf("vec%0d_valid", idx), 32'(ROB_input_valid), 32'(v.e_v));
    chk($sformatf("vec%0d_rb", idx), 32'(ROB_roll_back_flag), 32'(v.e_rb));
    if (v.e_v) begin
      chk($sformatf("vec%0d_rd", idx), 32'(ROB_rd), 32'(v.e_rd));
      chk($sformatf("vec%0d_value", idx), ROB_value, v.e_val);
      chk($sformatf("vec%0d_id", idx), 32'(ROB_rd_ROB_id), 32'(v.e_id));
    end
    if (v.e_rb) chk($sformatf("vec%0d_pc", idx), ROB_roll_back_pc, v.e_pc);
  endtask

  vec_t vecs[$];

  initial begin
    // rst al rd br  cv id val     mis tgt      aid full v rd val    id rb pc
    // Out-of-order completion, in-order commit.
    vecs.push_back('{1, 1, 5, 0,  0, 0, 0,      0, 0,       0, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 1, 6, 0,  0, 0, 0,      0, 0,       1, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 'h22,   0, 0,       2, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 0, 'h11,   0, 0,       2, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  0, 0, 0,      0, 0,       2, 0, 1, 5, 'h11,  0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  0, 0, 0,      0, 0,       2, 0, 1, 6, 'h22,  1, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  0, 0, 0,      0, 0,       2, 0, 0, 0, 0,     0, 0, 0});
    // Mispredicted branch at id2 with ids 3,4 already complete.
    vecs.push_back('{1, 1, 1, 0,  0, 0, 0,      0, 0,       0, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 1, 2, 0,  0, 0, 0,      0, 0,       1, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 1, 0, 1,  0, 0, 0,      0, 0,       2, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 1, 3, 0,  0, 0, 0,      0, 0,       3, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 1, 4, 0,  0, 0, 0,      0, 0,       4, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 3, 'h33,   0, 0,       5, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 4, 'h44,   0, 0,       5, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 2, 0,      1, 'h1000,  5, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 0, 'hA0,   0, 0,       5, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 'hA1,   0, 0,       5, 0, 1, 1, 'hA0,  0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  0, 0, 0,      0, 0,       5, 0, 1, 2, 'hA1,  1, 0, 0});
    vecs.push_back('{0, 1, 7, 0,  1, 3, 'h99,   0, 0,       5, 0, 0, 0, 0,     0, 1, 'h1000});
    vecs.push_back('{0, 0, 0, 0,  0, 0, 0,      0, 0,       0, 0, 0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  0, 0, 0,      0, 0,       0, 0, 0, 0, 0,     0, 0, 0});

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Fill to 16, dropped 17th alloc, commit frees a slot, wrap-around drain.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ID_alloc_valid = 1'b1;
      ID_rd          = 5'(i + 1);
      #1;
      chk($sformatf("fill%0d_aid", i), 32'(alloc_ROB_id), 32'(i));
      chk($sformatf("fill%0d_full", i), 32'(ROB_full), 0);
      step();
    end
    ID_alloc_valid = 1'b0;
    #1;
    chk("full_set", 32'(ROB_full), 1);
    chk("full_aid_wrap", 32'(alloc_ROB_id), 0);
    ID_alloc_valid = 1'b1;
    ID_rd          = 5'd31;
    step();
    ID_alloc_valid = 1'b0;
    #1;
    chk("drop_full", 32'(ROB_full), 1);
    chk("drop_aid", 32'(alloc_ROB_id), 0);
    CDB_valid  = 1'b1;
    CDB_ROB_id = 4'd0;
    CDB_value  = 32'h200;
    step();
    CDB_valid = 1'b0;
    chk("full_c0_early", 32'(ROB_input_valid), 0);
    step();
    chk("full_c0_valid", 32'(ROB_input_valid), 1);
    chk("full_c0_rd", 32'(ROB_rd), 1);
    chk("full_c0_value", ROB_value, 32'h200);
    chk("full_c0_full", 32'(ROB_full), 0);
    ID_alloc_valid = 1'b1;
    ID_rd          = 5'd17;
    #1;
    chk("refill_aid", 32'(alloc_ROB_id), 0);
    step();
    ID_alloc_valid = 1'b0;
    #1;
    chk("refill_full", 32'(ROB_full), 1);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = (k == 15) ? 0 : k + 1;
      CDB_valid  = 1'b1;
      CDB_ROB_id = 4'(j);
      CDB_value  = (j == 0) ? 32'h300 : 32'h200 + 32'(j);
      step();
      if (k > 0) begin
        chk($sformatf("wrap%0d_valid", k), 32'(ROB_input_valid), 1);
        chk($sformatf("wrap%0d_rd", k), 32'(ROB_rd), 32'(k + 1));
        chk($sformatf("wrap%0d_id", k), 32'(ROB_rd_ROB_id), 32'(k));
      end
    end
    CDB_valid = 1'b0;
    step();
    chk("wrap_last_valid", 32'(ROB_input_valid), 1);
    chk("wrap_last_rd", 32'(ROB_rd), 17);
    chk("wrap_last_value", ROB_value, 32'h300);
    chk("wrap_last_id", 32'(ROB_rd_ROB_id), 0);
    step();
    chk("wrap_idle_valid", 32'(ROB_input_valid), 0);
    chk("wrap_end_aid", 32'(alloc_ROB_id), 1);
    chk("wrap_end_full", 32'(ROB_full), 0);

    // x0 entry pops silently; query port.
    do_reset();
    ID_alloc_valid = 1'b1;
    ID_rd          = 5'd0;
    step();
    ID_rd = 5'd9;
    step();
    ID_alloc_valid = 1'b0;
    CDB_valid      = 1'b1;
    CDB_ROB_id     = 4'd0;
    CDB_value      = 32'h55;
    step();
    CDB_valid    = 1'b0;
    query_ROB_id = 4'd0;
    #1;
    chk("q0_ready", 32'(query_ready), 1);
    chk("q0_value", query_value, 32'h55);
    query_ROB_id = 4'd5;
    #1;
    chk("q5_ready", 32'(query_ready), 0);
    query_ROB_id = 4'd1;
    #1;
    chk("q1_not_ready", 32'(query_ready), 0);
    step();
    chk("x0_valid", 32'(ROB_input_valid), 0);
    query_ROB_id = 4'd0;
    #1;
    chk("q0_after_pop", 32'(query_ready), 0);
    CDB_valid  = 1'b1;
    CDB_ROB_id = 4'd1;
    CDB_value  = 32'h99;
    step();
    CDB_valid = 1'b0;
    step();
    chk("x0_next_valid", 32'(ROB_input_valid), 1);
    chk("x0_next_rd", 32'(ROB_rd), 9);
    chk("x0_next_id", 32'(ROB_rd_ROB_id), 1);

    // Asynchronous reset mid-stream with five entries still busy.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ID_alloc_valid = 1'b1;
      ID_rd          = 5'(i + 1);
      CDB_valid      = (i == 5);
      CDB_ROB_id     = 4'd0;
      CDB_value      = 32'h77;
      step();
    end
    clear_inputs();
    step();
    chk("mid_pre_valid", 32'(ROB_input_valid), 1);
    chk("mid_pre_value", ROB_value, 32'h77);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_valid", 32'(ROB_input_valid), 0);
    chk("mid_rd", 32'(ROB_rd), 0);
    chk("mid_value", ROB_value, 0);
    chk("mid_id", 32'(ROB_rd_ROB_id), 0);
    chk("mid_rb", 32'(ROB_roll_back_flag), 0);
    chk("mid_pc", ROB_roll_back_pc, 0);
    chk("mid_aid", 32'(alloc_ROB_id), 0);
    chk("mid_full", 32'(ROB_full), 0);
    query_ROB_id = 4'd1;
    #1;
    chk("mid_query", 32'(query_ready), 0);
    step();
    rst            = 1'b1;
    ID_alloc_valid = 1'b1;
    ID_rd          = 5'd3;
    #1;
    chk("post_rst_aid0", 32'(alloc_ROB_id), 0);
    step();
    ID_alloc_valid = 1'b0;
    #1;
    chk("post_rst_aid1", 32'(alloc_ROB_id), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
